// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter steering a shared 4:1 mux: owner holds until its request drops.
// Optional per-owner time quantum enabled with the MUX_ARB_QUANTUM_EN macro.
module mux_rr_arbiter #(
   parameter int QUANTUM = 8,
   parameter int QCNT_W  = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] req,
   input  logic [3:0] in,
   output logic [3:0] grant,
   output logic [1:0] sel,
   output logic       valid,
   output logic       out
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   if (QUANTUM < 1 || (2 ** QCNT_W) < QUANTUM) begin : g_bad_cfg
      $error("mux_rr_arbiter: QUANTUM must be >= 1 and fit in QCNT_W bits");
   end

   state_t     state_q, state_d;
   logic [3:0] grant_q, grant_d;
   logic [1:0] sel_q, sel_d;
   logic [1:0] last_q, last_d;
   logic [3:0] others;
   logic [1:0] pick_any, pick_next;
   logic [3:0] onehot_any, onehot_next;
`ifdef MUX_ARB_QUANTUM_EN
   localparam logic [QCNT_W-1:0] QMAX = QCNT_W'(QUANTUM - 1);
   logic [QCNT_W-1:0] qcnt_q, qcnt_d;
`endif

   // First set bit of r scanning base+1, base+2, base+3, base (mod 4).
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
      logic [1:0] idx;
      logic [1:0] res;
      logic       found;
      res   = base;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = base + 2'(k);
         if (!found && r[idx]) begin
            res   = idx;
            found = 1'b1;
         end
      end
      return res;
   endfunction

   // The owner's bit is masked so a handover never re-selects the current owner.
   assign others    = req & ~grant_q;
   assign pick_any  = rr_pick(req, last_q);
   assign pick_next = rr_pick(others, sel_q);

   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_dec
      assign onehot_any[gi]  = (pick_any == 2'(gi));
      assign onehot_next[gi] = (pick_next == 2'(gi));
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      last_d  = last_q;
`ifdef MUX_ARB_QUANTUM_EN
      qcnt_d  = qcnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = BUSY;
               grant_d = onehot_any;
               sel_d   = pick_any;
`ifdef MUX_ARB_QUANTUM_EN
               qcnt_d  = '0;
`endif
            end
         end
         BUSY: begin
            if (req[sel_q]) begin
`ifdef MUX_ARB_QUANTUM_EN
               if (qcnt_q == QMAX && |others) begin
                  last_d  = sel_q;
                  grant_d = onehot_next;
                  sel_d   = pick_next;
                  qcnt_d  = '0;
               end else if (qcnt_q != QMAX) begin
                  qcnt_d = qcnt_q + 1'b1;
               end
`endif
            end else begin
               last_d = sel_q;
               if (|others) begin
                  grant_d = onehot_next;
                  sel_d   = pick_next;
`ifdef MUX_ARB_QUANTUM_EN
                  qcnt_d  = '0;
`endif
               end else begin
                  grant_d = '0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         sel_q   <= 2'b00;
         last_q  <= 2'd3;
`ifdef MUX_ARB_QUANTUM_EN
         qcnt_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
`ifdef MUX_ARB_QUANTUM_EN
         qcnt_q  <= qcnt_d;
`endif
      end
   end

   assign grant = grant_q;
   assign sel   = sel_q;
   assign valid = |grant_q;
   assign out   = in[sel_q] & valid;

endmodule
